// File: rtl/bip_sequencer.sv
// ---------------------------------------------------------------------------
// bip_sequencer
//
// Multi-cycle control sequencer for the BIP I accumulator core. Owns the
// program counter and instruction register, fetches from the synchronous
// program memory, presents the opcode to the external instruction decoder,
// turns the decoder's WrAcc/WrRam into single-cycle write strobes on the
// final cycle of each instruction, inserts data-memory wait cycles for
// RdRam instructions and stops the core on HLT.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   run         in   1 = execute, 0 = stop at the next instruction boundary
//   instr_in    in   program memory read data (one cycle after pm_addr)
//   rd_ram      in   decoder RdRam for the current ir_opcode
//   wr_acc      in   decoder WrAcc
//   wr_ram      in   decoder WrRam
//   pm_addr     out  program memory address, always equal to PC
//   ir_opcode   out  IR[15:11], to the decoder
//   ir_operand  out  IR[10:0], to data memory address / immediate path
//   acc_we      out  accumulator write strobe (final cycle only)
//   ram_we      out  data memory write strobe (final cycle only)
//   halted      out  core stopped on HLT
//   illegal_op  out  sticky flag: an opcode > 7 was executed
//   retired     out  number of completed instructions (HLT excluded)
// ---------------------------------------------------------------------------
module bip_sequencer #(
    parameter int                  PC_WIDTH     = 11,
    parameter int                  INSTR_WIDTH  = 16,
    parameter int                  DM_LAT       = 1,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   rd_ram,
    input  logic                   wr_acc,
    input  logic                   wr_ram,
    output logic [PC_WIDTH-1:0]    pm_addr,
    output logic [4:0]             ir_opcode,
    output logic [10:0]            ir_operand,
    output logic                   acc_we,
    output logic                   ram_we,
    output logic                   halted,
    output logic                   illegal_op,
    output logic [15:0]            retired
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        EXEC    = 3'd3,
        MEMWAIT = 3'd4,
        HALT    = 3'd5
    } state_t;

    // Value of the wait counter in the last MEMWAIT cycle.
    localparam logic [2:0] WAIT_LAST = (DM_LAT > 0) ? 3'(DM_LAT - 1) : 3'd0;
    localparam bit         HAS_WAIT  = (DM_LAT > 0);

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic [2:0]             waitCnt;
    logic [15:0]            retiredCnt;
    logic                   haltedReg;
    logic                   illegalReg;

    logic [4:0] opcode;
    logic       isHlt;
    logic       isIllegal;
    logic       enterWait;
    logic       finalCycle;

    assign opcode    = ir[INSTR_WIDTH-1 -: 5];
    assign isHlt     = (opcode == 5'd0);
    // Only opcodes 0..7 exist in BIP I; anything with the upper bits set is
    // retired as a NOP and the decoder outputs are ignored for it.
    assign isIllegal = (opcode[4:3] != 2'b00);

    assign enterWait = (state == EXEC) && !isHlt && !isIllegal && rd_ram && HAS_WAIT;

    // The strobes are combinational, so the reset term keeps them quiet in
    // the reset cycle even if the FSM was sitting in a final cycle.
    assign finalCycle = !reset &&
                        (((state == EXEC) && !isHlt && !enterWait) ||
                         ((state == MEMWAIT) && (waitCnt == WAIT_LAST)));

    assign acc_we = finalCycle && !isIllegal && wr_acc;
    assign ram_we = finalCycle && !isIllegal && wr_ram;

    assign pm_addr    = pc;
    assign ir_opcode  = opcode;
    assign ir_operand = ir[10:0];
    assign halted     = haltedReg;
    assign illegal_op = illegalReg;
    assign retired    = retiredCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            ir         <= '0;
            waitCnt    <= 3'd0;
            retiredCnt <= 16'd0;
            haltedReg  <= 1'b0;
            illegalReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    // pm_addr is already PC; the memory answers next cycle.
                    state <= LOAD;
                end
                LOAD: begin
                    ir    <= instr_in;
                    state <= EXEC;
                end
                EXEC: begin
                    if (isHlt) begin
                        state     <= HALT;
                        haltedReg <= 1'b1;
                    end else if (enterWait) begin
                        waitCnt <= 3'd0;
                        state   <= MEMWAIT;
                    end
                end
                MEMWAIT: begin
                    if (waitCnt != WAIT_LAST) waitCnt <= waitCnt + 3'd1;
                end
                HALT: begin
                    // Only reset leaves HALT; run is ignored here.
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase

            // Retirement is common to EXEC and MEMWAIT final cycles; run is
            // sampled here so a dropped run never aborts an instruction.
            if (finalCycle) begin
                pc         <= pc + 1'b1;
                retiredCnt <= retiredCnt + 16'd1;
                state      <= run ? FETCH : IDLE;
                if (isIllegal) illegalReg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bip_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bip_sequencer
//
// Directed bench for bip_sequencer. Two instances share the clock:
//   dutA: DM_LAT = 2, RESET_VECTOR = 0x000
//   dutB: DM_LAT = 1, RESET_VECTOR = 0x7FF
// Each instance has its own synchronous program memory and a small model
// of the BIP I instruction decoder. Illegal opcodes make the decoder model
// assert every output so that strobe gating is visible.
// ---------------------------------------------------------------------------
module tb_bip_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- instance A ----
    logic        rstA, runA;
    logic [15:0] instrA;
    logic        rdA, wrAccA, wrRamA;
    logic [10:0] pmA;
    logic [4:0]  opA;
    logic [10:0] operandA;
    logic        accWeA, ramWeA, haltedA, illegalA;
    logic [15:0] retiredA;
    logic [15:0] memA [0:2047];

    // ---- instance B ----
    logic        rstB, runB;
    logic [15:0] instrB;
    logic        rdB, wrAccB, wrRamB;
    logic [10:0] pmB;
    logic [4:0]  opB;
    logic [10:0] operandB;
    logic        accWeB, ramWeB, haltedB, illegalB;
    logic [15:0] retiredB;
    logic [15:0] memB [0:2047];

    bip_sequencer #(.PC_WIDTH(11), .INSTR_WIDTH(16), .DM_LAT(2), .RESET_VECTOR(11'h000)) dutA (
        .clk(clk), .reset(rstA), .run(runA), .instr_in(instrA),
        .rd_ram(rdA), .wr_acc(wrAccA), .wr_ram(wrRamA),
        .pm_addr(pmA), .ir_opcode(opA), .ir_operand(operandA),
        .acc_we(accWeA), .ram_we(ramWeA), .halted(haltedA),
        .illegal_op(illegalA), .retired(retiredA)
    );

    bip_sequencer #(.PC_WIDTH(11), .INSTR_WIDTH(16), .DM_LAT(1), .RESET_VECTOR(11'h7FF)) dutB (
        .clk(clk), .reset(rstB), .run(runB), .instr_in(instrB),
        .rd_ram(rdB), .wr_acc(wrAccB), .wr_ram(wrRamB),
        .pm_addr(pmB), .ir_opcode(opB), .ir_operand(operandB),
        .acc_we(accWeB), .ram_we(ramWeB), .halted(haltedB),
        .illegal_op(illegalB), .retired(retiredB)
    );

    // Synchronous program memories.
    always_ff @(posedge clk) instrA <= memA[pmA];
    always_ff @(posedge clk) instrB <= memB[pmB];

    // Decoder model: {RdRam, WrAcc, WrRam}.
    function automatic logic [2:0] decode(input logic [4:0] op);
        case (op)
            5'd0:    decode = 3'b000; // HLT
            5'd1:    decode = 3'b001; // STO
            5'd2:    decode = 3'b110; // LD
            5'd3:    decode = 3'b010; // LDI
            5'd4:    decode = 3'b110; // ADD
            5'd5:    decode = 3'b010; // ADDI
            5'd6:    decode = 3'b110; // SUB
            5'd7:    decode = 3'b010; // SUBI
            default: decode = 3'b111; // garbage for illegal opcodes
        endcase
    endfunction

    always_comb {rdA, wrAccA, wrRamA} = decode(opA);
    always_comb {rdB, wrAccB, wrRamB} = decode(opB);

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opd);
        enc = {op, opd};
    endfunction

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            nPass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle logs filled by the sampling tasks (index = cycle offset).
    logic [31:0] accLog, ramLog, haltLog, illLog;
    int          pcLog  [32];
    int          retLog [32];

    task automatic sampleA(input int n);
        accLog = '0; ramLog = '0; haltLog = '0; illLog = '0;
        for (int i = 0; i < n; i++) begin
            accLog[i]  = accWeA;
            ramLog[i]  = ramWeA;
            haltLog[i] = haltedA;
            illLog[i]  = illegalA;
            pcLog[i]   = int'(pmA);
            retLog[i]  = int'(retiredA);
            tick();
        end
    endtask

    task automatic sampleB(input int n);
        accLog = '0; ramLog = '0; haltLog = '0; illLog = '0;
        for (int i = 0; i < n; i++) begin
            accLog[i]  = accWeB;
            ramLog[i]  = ramWeB;
            haltLog[i] = haltedB;
            illLog[i]  = illegalB;
            pcLog[i]   = int'(pmB);
            retLog[i]  = int'(retiredB);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstA = 1'b1; runA = 1'b0;
        rstB = 1'b1; runB = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            memA[a] = 16'h0000;
            memB[a] = 16'h0000;
        end

        // ---------------- Test 1: LDI 5; ADDI 3; STO 0x010; HLT ----------------
        memA[0] = enc(5'd3, 11'd5);
        memA[1] = enc(5'd5, 11'd3);
        memA[2] = enc(5'd1, 11'h010);
        memA[3] = enc(5'd0, 11'd0);
        runA = 1'b1;
        tick(); tick();
        checkVal("rst_pm",      pmA,      0);
        checkVal("rst_acc_we",  accWeA,   0);
        checkVal("rst_ram_we",  ramWeA,   0);
        checkVal("rst_halted",  haltedA,  0);
        checkVal("rst_illegal", illegalA, 0);
        checkVal("rst_retired", retiredA, 0);
        checkVal("rst_opcode",  opA,      0);
        rstA = 1'b0;
        sampleA(16);
        checkVal("t1_acc_mask",  accLog[15:0],  16'h0048);
        checkVal("t1_ram_mask",  ramLog[15:0],  16'h0200);
        checkVal("t1_halt_mask", haltLog[15:0], 16'hE000);
        checkVal("t1_fetch0",    pcLog[1],  0);
        checkVal("t1_fetch1",    pcLog[4],  1);
        checkVal("t1_fetch2",    pcLog[7],  2);
        checkVal("t1_fetch3",    pcLog[10], 3);
        checkVal("t1_pc_halt",   pcLog[15], 3);
        checkVal("t1_retired",   retiredA,  3);

        // ---------------- Test 2: DM_LAT=2, LD 0x004; HLT ----------------
        rstA = 1'b1;
        memA[0] = enc(5'd2, 11'h004);
        memA[1] = enc(5'd0, 11'd0);
        tick();
        rstA = 1'b0;
        sampleA(10);
        checkVal("t2_acc_mask",  accLog[9:0],  10'h020);
        checkVal("t2_ram_mask",  ramLog[9:0],  10'h000);
        checkVal("t2_halt_mask", haltLog[9:0], 10'h200);
        checkVal("t2_fetch1",    pcLog[6], 1);
        checkVal("t2_retired",   retiredA, 1);

        // ---------------- Test 4: illegal opcode 0x1F, then LDI 7; HLT ----------------
        rstA = 1'b1;
        memA[0] = enc(5'h1F, 11'h000);
        memA[1] = enc(5'd3, 11'd7);
        memA[2] = enc(5'd0, 11'd0);
        tick();
        rstA = 1'b0;
        sampleA(11);
        checkVal("t4_acc_mask",  accLog[10:0],  11'h040);
        checkVal("t4_ram_mask",  ramLog[10:0],  11'h000);
        checkVal("t4_ill_mask",  illLog[10:0],  11'h7F0);
        checkVal("t4_halt_mask", haltLog[10:0], 11'h400);
        checkVal("t4_pc_after",  pcLog[4],  1);
        checkVal("t4_ret_after", retLog[4], 1);
        checkVal("t4_retired",   retiredA,  2);

        // ---------------- Test 5: reset during MEMWAIT of LD ----------------
        rstA = 1'b1;
        memA[0] = enc(5'h1F, 11'h000);
        memA[1] = enc(5'd2, 11'h004);
        memA[2] = enc(5'd0, 11'd0);
        tick();
        rstA = 1'b0;
        sampleA(7);
        // now in the first MEMWAIT cycle of the LD
        checkVal("t5_mw_acc",     accWeA,   0);
        checkVal("t5_mw_illegal", illegalA, 1);
        rstA = 1'b1;
        runA = 1'b0;
        tick();
        checkVal("t5_acc_we",  accWeA,   0);
        checkVal("t5_pm",      pmA,      0);
        checkVal("t5_retired", retiredA, 0);
        checkVal("t5_illegal", illegalA, 0);
        rstA = 1'b0;
        sampleA(4);
        checkVal("t5_idle_acc", accLog[3:0], 4'h0);
        checkVal("t5_idle_pm",  pcLog[3],    0);

        // ---------------- Test 6: drop run during LOAD of ADDI ----------------
        rstA = 1'b1;
        runA = 1'b1;
        memA[0] = enc(5'd5, 11'd2);
        memA[1] = enc(5'd3, 11'd9);
        memA[2] = enc(5'd0, 11'd0);
        tick();
        rstA = 1'b0;
        tick(); tick();           // cycle 2: LOAD
        runA = 1'b0;
        sampleA(5);               // cycles 2..6
        checkVal("t6_acc_mask",  accLog[4:0], 5'h02);
        checkVal("t6_idle_pm",   pcLog[4],    1);
        checkVal("t6_idle_ret",  retiredA,    1);
        checkVal("t6_idle_halt", haltedA,     0);
        runA = 1'b1;
        sampleA(8);               // cycles 7..14
        checkVal("t6_res_acc",   accLog[7:0],  8'h08);
        checkVal("t6_res_fetch", pcLog[1],     1);
        checkVal("t6_res_next",  pcLog[4],     2);
        checkVal("t6_res_halt",  haltLog[7:0], 8'h80);
        runA = 1'b0;
        sampleA(3);
        checkVal("t6_halt_hold", haltLog[2:0], 3'h7);
        checkVal("t6_retired",   retiredA,     2);
        rstA = 1'b1;
        tick();
        checkVal("t6_rst_halted", haltedA, 0);
        checkVal("t6_rst_pm",     pmA,     0);
        rstA = 1'b0;

        // ---------------- Test 3 (dutB): PC wrap from 0x7FF, DM_LAT=1 ----------------
        memB[11'h7FF] = enc(5'd3, 11'd1);
        memB[0]       = enc(5'd2, 11'h004);
        memB[1]       = enc(5'd0, 11'd0);
        runB = 1'b1;
        tick();
        checkVal("t3_rst_pm", pmB, 32'h7FF);
        rstB = 1'b0;
        sampleB(12);
        checkVal("t3_fetch_7ff", pcLog[1], 32'h7FF);
        checkVal("t3_fetch_wrap", pcLog[4], 0);
        checkVal("t3_fetch_1",   pcLog[8], 1);
        checkVal("t3_acc_mask",  accLog[11:0],  12'h088);
        checkVal("t3_halt_mask", haltLog[11:0], 12'h800);
        checkVal("t3_retired",   retiredB, 2);
        checkVal("t3_illegal",   illegalB, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bip_sequencer.md
Name: bip_sequencer

Overview:
Multi-cycle control sequencer for the BIP I accumulator core. It owns the program counter and instruction register, fetches from the synchronous program memory and presents the opcode to the instruction decoder. It gates the decoder's WrAcc/WrRam into single-cycle write strobes at the correct point, inserts data-memory wait cycles for RdRam instructions, and stops the core on HLT.

Parameters:
PC_WIDTH, 11, program counter / program memory address width (equals operand width)
INSTR_WIDTH, 16, instruction width; opcode = [15:11], operand = [10:0]
DM_LAT, 1, data-memory read latency in cycles (0..7); 0 means no wait state
RESET_VECTOR, 0, PC value after reset

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
instr_in  input  INSTR_WIDTH  program memory read data, valid the cycle after pm_addr is presented
rd_ram  input  1  RdRam from instruction decoder, for current ir_opcode
wr_acc  input  1  WrAcc from instruction decoder
wr_ram  input  1  WrRam from instruction decoder
pm_addr  output  PC_WIDTH  program memory address (= PC)
ir_opcode  output  5  IR[15:11], drives decoder Opcode
ir_operand  output  11  IR[10:0], to data memory address / immediate path
acc_we  output  1  accumulator write strobe
ram_we  output  1  data memory write strobe
halted  output  1  core stopped on HLT
illegal_op  output  1  sticky: an opcode > 7 was executed
retired  output  16  count of completed instructions (HLT excluded)

Behaviour:
- Reset: state IDLE, PC = RESET_VECTOR, IR = 0, acc_we = ram_we = 0, halted = 0, illegal_op = 0, retired = 0. Reset wins over every other event in every state, including mid-instruction and HALT. Strobes are 0 in the reset cycle.
- States: IDLE, FETCH, LOAD, EXEC, MEMWAIT, HALT.
- IDLE: when run = 1, go to FETCH. Otherwise hold.
- FETCH: pm_addr = PC. Always go to LOAD.
- LOAD: IR <= instr_in. Go to EXEC.
- EXEC: decoder outputs are valid for IR.
  - Opcode 0 (HLT): go to HALT. No strobes, PC unchanged, retired unchanged.
  - rd_ram = 1 and DM_LAT > 0: load wait counter with 0, go to MEMWAIT. No strobes.
  - Otherwise EXEC is the final cycle of the instruction.
- MEMWAIT: increment counter each cycle. The cycle where counter = DM_LAT-1 is the final cycle.
- Final cycle of any instruction:
  - acc_we = wr_acc, ram_we = wr_ram (one-cycle pulses; combinational from state and decoder inputs).
  - PC <= PC+1, wrapping from 2^PC_WIDTH-1 to 0.
  - retired <= retired+1, wrapping at 16 bits.
  - Next state is FETCH if run = 1, else IDLE.
- Opcode > 7: decoder outputs ignored and both strobes forced 0. Treated as a NOP retired in EXEC. illegal_op set and held until reset.
- Latency: non-read instructions (STO, LDI, ADDI, SUBI, illegal) take 3 cycles. LD/ADD/SUB take 3 + DM_LAT cycles.
- run is sampled only in IDLE and in the final cycle. Deasserting run never aborts an instruction in flight.
- HALT: halted = 1. Hold forever, ignoring run; only reset exits.
- acc_we and ram_we are never asserted outside a final cycle. They are never asserted together for legal BIP I opcodes, since the decoder guarantees this.
- pm_addr always equals PC, including in IDLE and HALT.

Test Plan:
1. Reset, run = 1, program {LDI 5; ADDI 3; STO 0x010; HLT} at addresses 0-3, DM_LAT = 1 -> pm_addr 0,1,2,3 across 3-cycle instructions. acc_we pulses in cycles 3 and 6, ram_we in cycle 9. halted = 1 at cycle 13 and stays 1; retired = 3.
2. DM_LAT = 2, program {LD 0x004; HLT} -> EXEC, then MEMWAIT for 2 cycles. acc_we is a single pulse in the 2nd MEMWAIT cycle (instruction length 5 cycles); retired = 1.
3. RESET_VECTOR = 0x7FF, instruction LDI 1 -> after retirement PC wraps to 0x000 and the next fetch is at pm_addr = 0.
4. Opcode 0x1F at address 0 -> no acc_we/ram_we; illegal_op = 1 from the final cycle onward; PC = 1, retired = 1. illegal_op still 1 after the next instruction.
5. Assert reset during MEMWAIT of an LD -> next cycle state IDLE, PC = RESET_VECTOR, no acc_we pulse, retired = 0, illegal_op = 0.
6. Drop run during LOAD of ADDI -> the instruction completes with an acc_we pulse and the core parks in IDLE with PC+1. Re-raising run resumes fetching at that PC. Reset during HALT clears halted.
